// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the fetch/PC stage
package fetch_pkg;

    typedef enum logic [1:0] {IDLE, RUN, HALT} fetch_state_t;

    localparam int DEFAULT_PC_W  = 10;
    localparam int DEFAULT_LUT_W = 4;

    // Branch target table: entry i jumps to address i*16
    localparam logic [DEFAULT_PC_W-1:0] BR_TARGETS [2**DEFAULT_LUT_W] = '{
        10'd0,   10'd16,  10'd32,  10'd48,
        10'd64,  10'd80,  10'd96,  10'd112,
        10'd128, 10'd144, 10'd160, 10'd176,
        10'd192, 10'd208, 10'd224, 10'd240
    };

endpackage

// File: rtl/br_target_lut.sv
// rtl/br_target_lut.sv - combinational branch-target ROM
module br_target_lut
    import fetch_pkg::*;
#(
    parameter int PC_W  = DEFAULT_PC_W,
    parameter int LUT_W = DEFAULT_LUT_W
) (
    input  logic [LUT_W-1:0] br_idx,
    output logic [PC_W-1:0]  target
);

    assign target = PC_W'(BR_TARGETS[br_idx]);

endmodule

// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - program counter, compare flag and run/halt handshake
module fetch_pc_unit
    import fetch_pkg::*;
#(
    parameter int PC_W  = DEFAULT_PC_W,
    parameter int LUT_W = DEFAULT_LUT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             cmp_valid,
    input  logic             br_logic,
    input  logic             br_en,
    input  logic [LUT_W-1:0] br_idx,
    input  logic             halt_req,
    output logic [PC_W-1:0]  pc,
    output logic             running,
    output logic             done
);

    fetch_state_t    state;
    logic            flag;
    logic [PC_W-1:0] br_target;

    br_target_lut #(
        .PC_W  (PC_W),
        .LUT_W (LUT_W)
    ) u_lut (
        .br_idx (br_idx),
        .target (br_target)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            pc      <= '0;
            flag    <= 1'b0;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE, HALT: begin
                    if (start) begin
                        state   <= RUN;
                        pc      <= '0;
                        flag    <= 1'b0;
                        running <= 1'b1;
                        done    <= 1'b0;
                    end
                end
                RUN: begin
                    // Branch below reads the pre-update flag when CMP shares the cycle
                    if (cmp_valid)
                        flag <= br_logic;
                    if (halt_req) begin
                        state   <= HALT;
                        running <= 1'b0;
                        done    <= 1'b1;
                    end else if (br_en && flag) begin
                        pc <= br_target;
                    end else begin
                        pc <= pc + PC_W'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb/tb_fetch_pc_unit.sv - directed self-checking bench for fetch_pc_unit
module tb_fetch_pc_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       cmp_valid;
    logic       br_logic;
    logic       br_en;
    logic [3:0] br_idx;
    logic       halt_req;
    logic [9:0] pc;
    logic       running;
    logic       done;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fetch_pc_unit dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .cmp_valid (cmp_valid),
        .br_logic  (br_logic),
        .br_en     (br_en),
        .br_idx    (br_idx),
        .halt_req  (halt_req),
        .pc        (pc),
        .running   (running),
        .done      (done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        start = 0; cmp_valid = 0; br_logic = 0; br_en = 0; br_idx = 0; halt_req = 0;
    endtask

    task automatic check_state(input string tag, input int epc, input bit erun,
                               input bit edone, input bit eflag);
        check({tag, "_pc"},      32'(pc),       32'(epc));
        check({tag, "_running"}, 32'(running),  32'(erun));
        check({tag, "_done"},    32'(done),     32'(edone));
        check({tag, "_flag"},    32'(dut.flag), 32'(eflag));
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        step();
        step();
        reset = 0;
        check_state("reset", 0, 0, 0, 0);

        // inputs other than start ignored in IDLE
        br_en = 1; cmp_valid = 1; br_logic = 1; halt_req = 1;
        step();
        idle_inputs();
        check_state("idle_ignore", 0, 0, 0, 0);

        start = 1;
        step();
        start = 0;
        check_state("start", 0, 1, 0, 0);
        for (int i = 1; i <= 4; i++) begin
            step();
            check($sformatf("seq_pc%0d", i), 32'(pc), 32'(i));
        end
        check("seq_running", 32'(running), 32'd1);
        check("seq_done", 32'(done), 32'd0);

        // CMP equal at pc=4, taken branch at pc=5 to entry 3
        cmp_valid = 1; br_logic = 1;
        step();
        idle_inputs();
        check_state("cmp_eq", 5, 1, 0, 1);
        br_en = 1; br_idx = 3;
        step();
        idle_inputs();
        check_state("br_taken", 48, 1, 0, 1);

        // CMP not-equal, branch falls through
        cmp_valid = 1; br_logic = 0;
        step();
        idle_inputs();
        check_state("cmp_ne", 49, 1, 0, 0);
        br_en = 1; br_idx = 3;
        step();
        idle_inputs();
        check_state("br_not_taken", 50, 1, 0, 0);

        // same-cycle CMP and branch: branch uses old flag
        cmp_valid = 1; br_logic = 1;
        step();
        check_state("cmp_set", 51, 1, 0, 1);
        cmp_valid = 1; br_logic = 0; br_en = 1; br_idx = 15;
        step();
        idle_inputs();
        check_state("same_cycle", 240, 1, 0, 0);
        br_en = 1; br_idx = 15;
        step();
        idle_inputs();
        check_state("second_br", 241, 1, 0, 0);

        // halt wins over branch, flag still updates
        halt_req = 1; br_en = 1; br_idx = 2; cmp_valid = 1; br_logic = 1;
        step();
        idle_inputs();
        check_state("halt_mix", 241, 0, 1, 1);
        for (int i = 0; i < 10; i++) begin
            br_en = 1; br_idx = 5; cmp_valid = 1; br_logic = 0; halt_req = 1;
            step();
            check_state($sformatf("halt_hold%0d", i), 241, 0, 1, 1);
        end
        idle_inputs();

        start = 1;
        step();
        start = 0;
        check_state("restart", 0, 1, 0, 0);
        for (int i = 0; i < 7; i++) step();
        check("pc7", 32'(pc), 32'd7);
        halt_req = 1;
        step();
        idle_inputs();
        check_state("halt7", 7, 0, 1, 0);
        for (int i = 0; i < 10; i++) begin
            step();
            check($sformatf("halt7_hold%0d", i), 32'({pc, done, running}), 32'({10'd7, 1'b1, 1'b0}));
        end
        start = 1;
        step();
        start = 0;
        check_state("restart7", 0, 1, 0, 0);

        // reset mid-run at pc=20 with flag set
        cmp_valid = 1; br_logic = 1;
        step();
        idle_inputs();
        for (int i = 0; i < 19; i++) step();
        check_state("pre_reset", 20, 1, 0, 1);
        reset = 1; start = 1; br_en = 1; br_idx = 1;
        step();
        reset = 0;
        idle_inputs();
        check_state("mid_reset", 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step();
        check_state("post_reset_idle", 0, 0, 0, 0);

        // free-run to the top of the address space and wrap
        start = 1;
        step();
        start = 0;
        check_state("wrap_start", 0, 1, 0, 0);
        for (int i = 1; i <= 1023; i++) begin
            step();
            if (done !== 1'b0 || running !== 1'b1)
                check($sformatf("wrap_ctl%0d", i), 32'({done, running}), 32'({1'b0, 1'b1}));
        end
        check("wrap_top", 32'(pc), 32'd1023);
        step();
        check_state("wrap_zero", 0, 1, 0, 0);
        step();
        check("wrap_one", 32'(pc), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Program-counter and branch-resolution stage of the 8-bit processor: consumes the ALU compare result (`br_logic`) and the decoder's branch indication, and produces the instruction address for the next fetch. It holds the compare flag between a CMP and the following branch, resolves branch targets through a small target lookup table, and runs a start/halt/done handshake with the test harness.

## Interface
Parameters:
- `PC_W`, 10, width of the program counter / instruction address.
- `LUT_W`, 4, width of the branch-target index; the LUT has 2**LUT_W entries.

Ports:
- `clk`  input  1  single clock; all state updates on its rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `start`  input  1  pulse; begins execution at address 0.
- `cmp_valid`  input  1  current instruction is CMP; `br_logic` is meaningful this cycle.
- `br_logic`  input  1  ALU equality result (1 = operands equal).
- `br_en`  input  1  current instruction is a branch.
- `br_idx`  input  LUT_W  branch-target table index from the instruction.
- `halt_req`  input  1  current instruction is HALT.
- `pc`  output  PC_W  current instruction address.
- `running`  output  1  high in RUN.
- `done`  output  1  high in HALT.

## Operation
- FSM states:
  - IDLE (reset state).
  - RUN.
  - HALT.
- FSM transitions:
  - IDLE→RUN on `start`.
  - RUN→HALT on `halt_req`.
  - HALT→RUN on `start`.
  - `start` in RUN is ignored.
- Entering RUN from IDLE or HALT loads `pc` = 0 and clears `flag`.
- In RUN, per cycle:
  - If `halt_req`: `pc` holds.
  - Else if `br_en` and `flag`: `pc` = `br_target[br_idx]` (taken).
  - Else: `pc` = `pc + 1`, modulo 2**PC_W, so 2**PC_W−1 wraps to 0.
- `flag` register:
  - Loaded with `br_logic` on any RUN cycle with `cmp_valid`.
  - Otherwise holds.
  - Not cleared by a taken branch; it persists until the next CMP, reset or start.
- Same-cycle `cmp_valid` and `br_en`: the branch uses the old `flag`, and `flag` takes the new value.
- Same-cycle `halt_req` with `br_en` or `cmp_valid`: halt wins, `pc` holds, and `flag` still updates.
- Inputs other than `start` are ignored in IDLE and HALT.
- Reset mid-operation: on the next edge, state = IDLE and all outputs return to reset values regardless of other inputs.

## Timing
- Reset values: `pc` = 0, `running` = 0, `done` = 0, `flag` = 0, state IDLE.
- All outputs are registered or decoded from registered state only; there is no combinational input→output path.
- `start` sampled at edge N: `running` = 1 and `pc` = 0 from N+1, and the first instruction executes in cycle N+1.
- Next-PC latency is one cycle: inputs sampled at edge N determine `pc` after edge N.
- `br_logic` from a CMP at cycle N is visible to a branch at cycle N+1 or later.
- `halt_req` at edge N gives `done` = 1 and `running` = 0 from N+1, with `pc` frozen at the HALT address.
- `done` stays high until `start` or `reset`.

## Structure
- Package `fetch_pkg`:
  - `typedef enum logic [1:0] {IDLE, RUN, HALT} fetch_state_t`.
  - `PC_W` and `LUT_W` defaults.
  - Constant array `BR_TARGETS`, with entry i = i*16 (entry 3 = 48, entry 15 = 240).
- Sub-module `br_target_lut`: purely combinational ROM indexed by `br_idx`, returning a PC_W-bit target from `BR_TARGETS`.
- FSM, PC register and flag register live in the top module.

## Test plan
- Reset, then pulse `start`, then run 5 cycles with no control inputs → `pc` sequence 0,1,2,3,4,5; `running` = 1; `done` = 0.
- CMP with `br_logic`=1 at `pc`=4, then `br_en` with `br_idx`=3 at `pc`=5 → `pc` = 48 next; repeat with `br_logic`=0 → `pc` = 6.
- `cmp_valid`+`br_logic`=0 and `br_en`+`br_idx`=15 in the same cycle with old `flag`=1 → `pc` = 240 and `flag` = 0 afterward; a second branch then falls through.
- Preload `pc` = 1023 via a branch to an entry overridden in the bench package (or free-run 1023 cycles), then step → `pc` = 0 with no glitch on `done`.
- `halt_req` at `pc`=7 → `done`=1 and `pc`=7 held for 10 cycles, ignoring `br_en`/`start`-free cycles; then `start` → `pc`=0, `running`=1, `flag`=0.
- Assert `reset` for one cycle while in RUN at `pc`=20 with `flag`=1 → next cycle `pc`=0, `flag`=0, `running`=0, `done`=0; `start` is required to resume.
